cfg_switchbox: RTL and testbench

CFG_SWITCHBOX -- requirements
Module: cfg_switchbox

---
 rtl/sb_pkg.sv | 66 ++++++
 rtl/sb_track_router.sv | 98 +++++++++
 rtl/cfg_switchbox.sv | 157 +++++++++++++++
 tb/tb_cfg_switchbox.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// +-----------------------------------------------------------------------+
// | sb_pkg : shared types, field layout and routing helpers for the       |
// |          configurable switchbox.                                      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package sb_pkg;

  localparam int SB_CFG_W = 9;
  localparam int SB_SIDES = 4;

  // Field offsets inside one per-track configuration word
  localparam int SB_MODE_BIT = 8;
  localparam int SB_N_LSB    = 6;
  localparam int SB_E_LSB    = 4;
  localparam int SB_S_LSB    = 2;
  localparam int SB_W_LSB    = 0;

  // Side indices run clockwise, so +1 is clockwise and -1 counter-clockwise
  localparam logic [1:0] SIDE_N = 2'd0;
  localparam logic [1:0] SIDE_E = 2'd1;
  localparam logic [1:0] SIDE_S = 2'd2;
  localparam logic [1:0] SIDE_W = 2'd3;

  typedef enum logic [1:0] {
    CODE_IDLE    = 2'b00,
    CODE_RECV    = 2'b01,
    CODE_DRIVE   = 2'b10,
    CODE_ILLEGAL = 2'b11
  } side_code_e;

  typedef enum logic {
    MODE_0 = 1'b0,
    MODE_1 = 1'b1
  } route_mode_e;

  function automatic side_code_e side_code(input logic [SB_CFG_W-1:0] word,
                                           input logic [1:0]          side);
    logic [1:0] code;
    case (side)
      SIDE_N:  code = word[SB_N_LSB +: 2];
      SIDE_E:  code = word[SB_E_LSB +: 2];
      SIDE_S:  code = word[SB_S_LSB +: 2];
      default: code = word[SB_W_LSB +: 2];
    endcase
    return side_code_e'(code);
  endfunction

  // Destination side of driver d in a two-driver track whose other driver is partner
  function automatic logic [1:0] route_dst(input logic [1:0]  d,
                                           input logic [1:0]  partner,
                                           input logic        opposite,
                                           input route_mode_e mode);
    logic [1:0] dst;
    if (!opposite) begin
      dst = (mode == MODE_0) ? d + 2'd2 : partner + 2'd2;
    end else begin
      dst = (mode == MODE_0) ? d - 2'd1 : d + 2'd1;
    end
    return dst;
  endfunction

endpackage : sb_pkg

`default_nettype wire

// File: rtl/sb_track_router.sv
// +-----------------------------------------------------------------------+
// | sb_track_router : combinational router for one track, decodes a       |
// |                   9-bit word into per-side data and output enables.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module sb_track_router
  import sb_pkg::*;
(
  input  logic [SB_CFG_W-1:0] cfg_i,
  input  logic [SB_SIDES-1:0] in_i,
  output logic [SB_SIDES-1:0] out_o,
  output logic [SB_SIDES-1:0] oe_o,
  output logic                err_o
);

  logic [SB_SIDES-1:0]      drv;
  logic [SB_SIDES-1:0]      rcv;
  logic                     ill;
  logic [2:0]               ndrv;
  logic [1:0]               drv_a;
  logic [1:0]               drv_b;
  logic                     opposite;
  logic                     err;
  route_mode_e              mode;
  logic [1:0]               dst_a;
  logic [1:0]               dst_b;
  logic [SB_SIDES-1:0]      routed;
  logic [SB_SIDES-1:0][1:0] src_sel;

  always_comb begin
    drv   = '0;
    rcv   = '0;
    ill   = 1'b0;
    ndrv  = 3'd0;
    drv_a = 2'd0;
    drv_b = 2'd0;
    for (int s = 0; s < SB_SIDES; s++) begin
      case (side_code(cfg_i, 2'(s)))
        CODE_DRIVE: begin
          drv[s] = 1'b1;
          if (ndrv == 3'd0) drv_a = 2'(s);
          else              drv_b = 2'(s);
          ndrv = ndrv + 3'd1;
        end
        CODE_RECV:    rcv[s] = 1'b1;
        CODE_ILLEGAL: ill    = 1'b1;
        default: ;
      endcase
    end
  end

  assign err      = ill || ((ndrv == 3'd0) && (|rcv)) || (ndrv >= 3'd3);
  assign opposite = ((drv_b - drv_a) == 2'd2);
  assign mode     = route_mode_e'(cfg_i[SB_MODE_BIT]);
  assign err_o    = err;

  // Two-driver tracks route onto the free sides whatever their code; only
  // receiver sides get an output enable.
  always_comb begin
    routed  = '0;
    src_sel = '0;
    dst_a   = route_dst(drv_a, drv_b, opposite, mode);
    dst_b   = route_dst(drv_b, drv_a, opposite, mode);
    if (!err) begin
      case (ndrv)
        3'd1: begin
          for (int j = 0; j < SB_SIDES; j++) begin
            if (rcv[j]) begin
              routed[j]  = 1'b1;
              src_sel[j] = drv_a;
            end
          end
        end
        3'd2: begin
          routed[dst_a]  = 1'b1;
          src_sel[dst_a] = drv_a;
          routed[dst_b]  = 1'b1;
          src_sel[dst_b] = drv_b;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_o = '0;
    oe_o  = '0;
    for (int j = 0; j < SB_SIDES; j++) begin
      out_o[j] = routed[j] & in_i[src_sel[j]];
      oe_o[j]  = routed[j] & rcv[j];
    end
  end

endmodule : sb_track_router

`default_nettype wire

// File: rtl/cfg_switchbox.sv
// +-----------------------------------------------------------------------+
// | cfg_switchbox : serially configured N/E/S/W switchbox with shadow and |
// |                 active frames. SB_OUT_REG_EN registers *_out / *_oe.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module cfg_switchbox
  import sb_pkg::*;
#(
  parameter int TRACKS = 4,
  parameter int FRAME  = TRACKS * SB_CFG_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cfg_in,
  input  logic              cfg_shift,
  input  logic              cfg_commit,
  output logic              cfg_out,
  output logic              cfg_ready,
  output logic              cfg_err,
  input  logic [TRACKS-1:0] n_in,
  input  logic [TRACKS-1:0] e_in,
  input  logic [TRACKS-1:0] s_in,
  input  logic [TRACKS-1:0] w_in,
  output logic [TRACKS-1:0] n_out,
  output logic [TRACKS-1:0] e_out,
  output logic [TRACKS-1:0] s_out,
  output logic [TRACKS-1:0] w_out,
  output logic [TRACKS-1:0] n_oe,
  output logic [TRACKS-1:0] e_oe,
  output logic [TRACKS-1:0] s_oe,
  output logic [TRACKS-1:0] w_oe,
  output logic [TRACKS-1:0] track_err
);

  localparam int               CNT_W     = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME);

  logic [FRAME-1:0] shadow_q, shadow_d;
  logic [FRAME-1:0] active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             frame_full;

  assign frame_full = (cnt_q == FRAME_CNT);
  assign cfg_out    = shadow_q[FRAME-1];
  assign cfg_ready  = frame_full;
  assign cfg_err    = err_q;

  // A commit takes priority and swallows any shift in the same cycle
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (cfg_commit) begin
      if (frame_full) begin
        active_d = shadow_q;
        cnt_d    = '0;
        err_d    = 1'b0;
      end else begin
        err_d    = 1'b1;
      end
    end else if (cfg_shift) begin
      shadow_d = {shadow_q[FRAME-2:0], cfg_in};
      if (!frame_full) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  logic [TRACKS-1:0] n_out_d, e_out_d, s_out_d, w_out_d;
  logic [TRACKS-1:0] n_oe_d, e_oe_d, s_oe_d, w_oe_d;

  for (genvar t = 0; t < TRACKS; t++) begin : g_track
    logic [SB_SIDES-1:0] trk_out;
    logic [SB_SIDES-1:0] trk_oe;

    sb_track_router u_router (
      .cfg_i (active_q[t*SB_CFG_W +: SB_CFG_W]),
      .in_i  ({w_in[t], s_in[t], e_in[t], n_in[t]}),
      .out_o (trk_out),
      .oe_o  (trk_oe),
      .err_o (track_err[t])
    );

    assign n_out_d[t] = trk_out[SIDE_N];
    assign e_out_d[t] = trk_out[SIDE_E];
    assign s_out_d[t] = trk_out[SIDE_S];
    assign w_out_d[t] = trk_out[SIDE_W];
    assign n_oe_d[t]  = trk_oe[SIDE_N];
    assign e_oe_d[t]  = trk_oe[SIDE_E];
    assign s_oe_d[t]  = trk_oe[SIDE_S];
    assign w_oe_d[t]  = trk_oe[SIDE_W];
  end

`ifdef SB_OUT_REG_EN
  logic [TRACKS-1:0] n_out_q, e_out_q, s_out_q, w_out_q;
  logic [TRACKS-1:0] n_oe_q, e_oe_q, s_oe_q, w_oe_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      n_out_q <= '0;
      e_out_q <= '0;
      s_out_q <= '0;
      w_out_q <= '0;
      n_oe_q  <= '0;
      e_oe_q  <= '0;
      s_oe_q  <= '0;
      w_oe_q  <= '0;
    end else begin
      n_out_q <= n_out_d;
      e_out_q <= e_out_d;
      s_out_q <= s_out_d;
      w_out_q <= w_out_d;
      n_oe_q  <= n_oe_d;
      e_oe_q  <= e_oe_d;
      s_oe_q  <= s_oe_d;
      w_oe_q  <= w_oe_d;
    end
  end

  assign n_out = n_out_q;
  assign e_out = e_out_q;
  assign s_out = s_out_q;
  assign w_out = w_out_q;
  assign n_oe  = n_oe_q;
  assign e_oe  = e_oe_q;
  assign s_oe  = s_oe_q;
  assign w_oe  = w_oe_q;
`else
  assign n_out = n_out_d;
  assign e_out = e_out_d;
  assign s_out = s_out_d;
  assign w_out = w_out_d;
  assign n_oe  = n_oe_d;
  assign e_oe  = e_oe_d;
  assign s_oe  = s_oe_d;
  assign w_oe  = w_oe_d;
`endif

endmodule : cfg_switchbox

`default_nettype wire

// File: tb/tb_cfg_switchbox.sv
// +-----------------------------------------------------------------------+
// | tb_cfg_switchbox : directed self-checking bench for cfg_switchbox     |
// |                    with TRACKS=4.                                     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_cfg_switchbox;

  // Frame layout {track3, track2, track1, track0}; bit 35 is shifted first
  localparam logic [35:0] FRAME_A = {9'b1_00_00_00_00, 9'b0_00_00_00_00,
                                     9'b0_10_10_00_00, 9'b0_10_01_01_00};
  localparam logic [35:0] FRAME_B = {9'b0_10_01_10_01, 9'b0_10_10_10_00,
                                     9'b1_10_10_00_00, 9'b0_10_01_01_00};

  logic       clk;
  logic       nrst;
  logic       cfg_in, cfg_shift, cfg_commit;
  logic       cfg_out, cfg_ready, cfg_err;
  logic [3:0] n_in, e_in, s_in, w_in;
  logic [3:0] n_out, e_out, s_out, w_out;
  logic [3:0] n_oe, e_oe, s_oe, w_oe;
  logic [3:0] track_err;

  int checks = 0;
  int errors = 0;

  cfg_switchbox #(.TRACKS(4)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .cfg_in     (cfg_in),
    .cfg_shift  (cfg_shift),
    .cfg_commit (cfg_commit),
    .cfg_out    (cfg_out),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .n_in       (n_in),
    .e_in       (e_in),
    .s_in       (s_in),
    .w_in       (w_in),
    .n_out      (n_out),
    .e_out      (e_out),
    .s_out      (s_out),
    .w_out      (w_out),
    .n_oe       (n_oe),
    .e_oe       (e_oe),
    .s_oe       (s_oe),
    .w_oe       (w_oe),
    .track_err  (track_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_routes(input string tag,
                              input logic [3:0] xn, input logic [3:0] xe,
                              input logic [3:0] xs, input logic [3:0] xw,
                              input logic [3:0] on, input logic [3:0] oe,
                              input logic [3:0] os, input logic [3:0] ow,
                              input logic [3:0] te);
    check({tag, ".n_out"}, 32'(n_out), 32'(xn));
    check({tag, ".e_out"}, 32'(e_out), 32'(xe));
    check({tag, ".s_out"}, 32'(s_out), 32'(xs));
    check({tag, ".w_out"}, 32'(w_out), 32'(xw));
    check({tag, ".n_oe"},  32'(n_oe),  32'(on));
    check({tag, ".e_oe"},  32'(e_oe),  32'(oe));
    check({tag, ".s_oe"},  32'(s_oe),  32'(os));
    check({tag, ".w_oe"},  32'(w_oe),  32'(ow));
    check({tag, ".track_err"}, 32'(track_err), 32'(te));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
`ifdef SB_OUT_REG_EN
    step();
`else
    #1;
`endif
  endtask

  task automatic shift_bits(input logic [35:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      cfg_shift = 1'b1;
      cfg_in    = f[i];
      step();
    end
    cfg_shift = 1'b0;
    cfg_in    = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; cfg_in = 1'b0; cfg_shift = 1'b0; cfg_commit = 1'b0;
    n_in = '0; e_in = '0; s_in = '0; w_in = '0;
    repeat (2) step();
    nrst = 1'b1;
    step();

    // Reset state
    check_routes("reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    check("reset.cfg_ready", 32'(cfg_ready), 32'd0);
    check("reset.cfg_err",   32'(cfg_err),   32'd0);
    check("reset.cfg_out",   32'(cfg_out),   32'd0);

    // Frame A: one-driver track0, adjacent-driver track1 in mode 0
    shift_bits(FRAME_A, 35, 1);
    check("a.ready35", 32'(cfg_ready), 32'd0);
    shift_bits(FRAME_A, 0, 0);
    check("a.ready36", 32'(cfg_ready), 32'd1);
    check("a.cfg_out", 32'(cfg_out),   32'd1);
    n_in = 4'b0011;
    settle();
    check_routes("a.pre", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    commit();
    settle();
    check_routes("a.m0", 4'b0000, 4'b0001, 4'b0011, 4'b0000,
                 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    n_in = 4'b0001; e_in = 4'b0010;
    settle();
    check_routes("a.m0b", 4'b0000, 4'b0001, 4'b0001, 4'b0010,
                 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000);

    // Early commit rejected, then completed frame B accepted
    shift_bits(FRAME_B, 35, 1);
    commit();
    check("b.err_set",   32'(cfg_err),   32'd1);
    check("b.ready_rej", 32'(cfg_ready), 32'd0);
    settle();
    check_routes("b.rej", 4'b0000, 4'b0001, 4'b0001, 4'b0010,
                 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    shift_bits(FRAME_B, 0, 0);
    check("b.err_sticky", 32'(cfg_err),   32'd1);
    check("b.ready36",    32'(cfg_ready), 32'd1);
    check("b.cfg_out",    32'(cfg_out),   32'd0);
    commit();
    check("b.err_clear",  32'(cfg_err),   32'd0);
    check("b.ready_acc",  32'(cfg_ready), 32'd0);
    n_in = 4'b1111; e_in = 4'b0000; s_in = 4'b0000; w_in = 4'b0000;
    settle();
    check_routes("b.acc", 4'b0000, 4'b0001, 4'b0001, 4'b1010,
                 4'b0000, 4'b1001, 4'b0001, 4'b1000, 4'b0100);
    n_in = 4'b0111; s_in = 4'b1000;
    settle();
    check_routes("b.acc2", 4'b0000, 4'b1001, 4'b0001, 4'b0010,
                 4'b0000, 4'b1001, 4'b0001, 4'b1000, 4'b0100);

    // Shift and commit together: commit only, shadow and count untouched
    shift_bits(FRAME_A, 35, 0);
    check("c.ready36", 32'(cfg_ready), 32'd1);
    check("c.cfg_out", 32'(cfg_out),   32'd1);
    cfg_shift = 1'b1; cfg_in = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_shift = 1'b0; cfg_commit = 1'b0;
    check("c.out_hold",  32'(cfg_out),   32'd1);
    check("c.ready_clr", 32'(cfg_ready), 32'd0);
    check("c.err",       32'(cfg_err),   32'd0);
    settle();
    check_routes("c.act", 4'b0000, 4'b0001, 4'b0011, 4'b0000,
                 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    shift_bits(FRAME_A, 35, 1);
    check("c.cnt35", 32'(cfg_ready), 32'd0);
    shift_bits(FRAME_A, 0, 0);
    check("c.cnt36", 32'(cfg_ready), 32'd1);

    // Asynchronous reset mid-shift
    n_in = 4'b0001; s_in = 4'b0000;
    commit();
    settle();
    check_routes("d.pre", 4'b0000, 4'b0001, 4'b0001, 4'b0000,
                 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    shift_bits(FRAME_A, 35, 16);
    check("d.ready20", 32'(cfg_ready), 32'd0);
    commit();
    check("d.err_set", 32'(cfg_err), 32'd1);
    cfg_shift = 1'b1; cfg_in = 1'b1;
    nrst = 1'b0;
    #2;
    check_routes("d.rst", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    check("d.rst.cfg_ready", 32'(cfg_ready), 32'd0);
    check("d.rst.cfg_err",   32'(cfg_err),   32'd0);
    check("d.rst.cfg_out",   32'(cfg_out),   32'd0);
    cfg_shift = 1'b0; cfg_in = 1'b0;
    repeat (2) step();
    nrst = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cfg_switchbox

`default_nettype wire
